// File: rtl/fpu_ss_wb_arbiter.sv
// FPU subsystem write-back arbiter: shares the FPR write port and the X-interface result
// channel between a fall-through FPnew result queue and memory load results.
module fpu_ss_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter bit          PULP_ZFINX = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fpu_valid_i,
  output logic                  fpu_ready_o,
  input  logic [4:0]            fpu_rd_i,
  input  logic                  fpu_rd_is_fp_i,
  input  logic [ID_WIDTH-1:0]   fpu_id_i,
  input  logic [DATA_WIDTH-1:0] fpu_data_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_we_i,
  input  logic [4:0]            mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  fpr_we_o,
  output logic [4:0]            fpr_waddr_o,
  output logic [DATA_WIDTH-1:0] fpr_wdata_o,
  output logic                  x_result_valid_o,
  input  logic                  x_result_ready_i,
  output logic [ID_WIDTH-1:0]   x_result_id_o,
  output logic [4:0]            x_result_rd_o,
  output logic [DATA_WIDTH-1:0] x_result_data_o,
  output logic                  wb_id_valid_o,
  output logic [ID_WIDTH-1:0]   wb_id_o,
  output logic [15:0]           stall_cnt_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]            q_rd   [FIFO_DEPTH];
  logic                  q_fp   [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   q_id   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic                  empty, full;
  logic                  head_valid, head_fp, head_is_fp;
  logic [4:0]            head_rd;
  logic [ID_WIDTH-1:0]   head_id;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  mem_wr, drain, push, pop, blocked;

  // Outputs are qualified with rst_ni so they drop immediately when reset asserts.
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(FIFO_DEPTH));
    if (!empty) begin
      head_fp   = q_fp[rd_ptr];
      head_rd   = q_rd[rd_ptr];
      head_id   = q_id[rd_ptr];
      head_data = q_data[rd_ptr];
    end else begin
      head_fp   = fpu_rd_is_fp_i;
      head_rd   = fpu_rd_i;
      head_id   = fpu_id_i;
      head_data = fpu_data_i;
    end
    head_valid = rst_ni & (~empty | fpu_valid_i);
    head_is_fp = head_fp & (PULP_ZFINX == 1'b0);
    mem_wr     = rst_ni & mem_valid_i & mem_we_i & (PULP_ZFINX == 1'b0);
    drain      = head_valid & (head_is_fp ? ~mem_wr : x_result_ready_i);
    blocked    = head_valid & head_is_fp & mem_wr;
    pop        = drain & ~empty;
    push       = fpu_valid_i & ~full & ~(empty & drain);
  end

  always_comb begin
    fpu_ready_o      = ~full;
    fpr_we_o         = 1'b0;
    fpr_waddr_o      = '0;
    fpr_wdata_o      = '0;
    x_result_valid_o = 1'b0;
    x_result_id_o    = '0;
    x_result_rd_o    = '0;
    x_result_data_o  = '0;
    wb_id_valid_o    = drain;
    wb_id_o          = drain ? head_id : '0;
    if (mem_wr) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = mem_rd_i;
      fpr_wdata_o = mem_data_i;
    end else if (head_valid && head_is_fp) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = head_rd;
      fpr_wdata_o = head_data;
    end
    if (head_valid && !head_is_fp) begin
      x_result_valid_o = 1'b1;
      x_result_id_o    = head_id;
      x_result_rd_o    = head_rd;
      x_result_data_o  = head_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rd[wr_ptr]   <= fpu_rd_i;
      q_fp[wr_ptr]   <= fpu_rd_is_fp_i;
      q_id[wr_ptr]   <= fpu_id_i;
      q_data[wr_ptr] <= fpu_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (blocked && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Scoreboard bench for fpu_ss_wb_arbiter: a queue-based reference model predicts write-backs,
// results and per-cycle status; a negedge monitor pops and compares.
module tb_fpu_ss_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fpu_valid, fpu_ready, fpu_rd_is_fp;
  logic [4:0]  fpu_rd;
  logic [3:0]  fpu_id;
  logic [31:0] fpu_data;
  logic        mem_valid, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;
  logic        x_valid, x_ready;
  logic [3:0]  x_id;
  logic [4:0]  x_rd;
  logic [31:0] x_data;
  logic        wb_valid;
  logic [3:0]  wb_id;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter #(.FIFO_DEPTH(2), .DATA_WIDTH(32), .ID_WIDTH(4), .PULP_ZFINX(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_rd_i(fpu_rd),
    .fpu_rd_is_fp_i(fpu_rd_is_fp), .fpu_id_i(fpu_id), .fpu_data_i(fpu_data),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr), .fpr_wdata_o(fpr_wdata),
    .x_result_valid_o(x_valid), .x_result_ready_i(x_ready), .x_result_id_o(x_id),
    .x_result_rd_o(x_rd), .x_result_data_o(x_data),
    .wb_id_valid_o(wb_valid), .wb_id_o(wb_id), .stall_cnt_o(stall_cnt)
  );

  typedef struct packed {
    logic fv; logic ffp; logic [4:0] frd; logic [3:0] fid; logic [31:0] fdata;
    logic mv; logic mwe; logic [4:0] mrd; logic [31:0] mdata; logic xr;
  } stim_t;
  typedef struct packed { logic fp; logic [4:0] rd; logic [3:0] id; logic [31:0] data; } ent_t;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct packed {
    logic we; logic xv; logic wbv; logic rdy; logic [15:0] stall; ent_t xh;
  } snap_t;

  ent_t  mq[$];
  int unsigned mstall;
  wr_t   exp_fpr[$];
  ent_t  exp_x[$];
  logic [3:0] exp_wb[$];
  snap_t snaps[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  // Drive one cycle of stimulus and predict the DUT's behaviour for that cycle.
  task automatic step(input stim_t s);
    snap_t sn;
    ent_t  h;
    logic  have, mw, drained, was_empty;
    @(posedge clk);
    #1;
    fpu_valid = s.fv; fpu_rd_is_fp = s.ffp; fpu_rd = s.frd; fpu_id = s.fid; fpu_data = s.fdata;
    mem_valid = s.mv; mem_we = s.mwe; mem_rd = s.mrd; mem_data = s.mdata; x_ready = s.xr;
    sn = '0;
    sn.rdy = (mq.size() < 2);
    sn.stall = mstall[15:0];
    have = 1'b1;
    if (mq.size() > 0) h = mq[0];
    else if (s.fv) h = '{fp: s.ffp, rd: s.frd, id: s.fid, data: s.fdata};
    else begin h = '0; have = 1'b0; end
    mw = s.mv & s.mwe;
    drained = 1'b0;
    if (mw) begin
      sn.we = 1'b1;
      exp_fpr.push_back('{a: s.mrd, d: s.mdata});
    end
    if (have) begin
      if (h.fp) begin
        if (mw) mstall = (mstall >= 65535) ? 65535 : mstall + 1;
        else begin
          sn.we = 1'b1;
          exp_fpr.push_back('{a: h.rd, d: h.data});
          drained = 1'b1;
        end
      end else begin
        sn.xv = 1'b1;
        sn.xh = h;
        if (s.xr) begin
          exp_x.push_back(h);
          drained = 1'b1;
        end
      end
    end
    if (drained) begin
      sn.wbv = 1'b1;
      exp_wb.push_back(h.id);
    end
    was_empty = (mq.size() == 0);
    if (drained && !was_empty) void'(mq.pop_front());
    if (s.fv && sn.rdy && !(was_empty && drained))
      mq.push_back('{fp: s.ffp, rd: s.frd, id: s.fid, data: s.fdata});
    snaps.push_back(sn);
  endtask

  always @(negedge clk) begin
    snap_t sn;
    wr_t   w;
    ent_t  e;
    logic [3:0] id;
    if (snaps.size() > 0) begin
      sn = snaps.pop_front();
      chk("fpu_ready", fpu_ready, sn.rdy);
      chk("stall_cnt", stall_cnt, sn.stall);
      chk("fpr_we", fpr_we, sn.we);
      chk("x_valid", x_valid, sn.xv);
      chk("wb_valid", wb_valid, sn.wbv);
      if (sn.xv) begin
        chk("x_id_held", x_id, sn.xh.id);
        chk("x_rd_held", x_rd, sn.xh.rd);
        chk("x_data_held", x_data, sn.xh.data);
      end
    end
    if (fpr_we) begin
      if (exp_fpr.size() == 0) unexpected("fpr_write");
      else begin
        w = exp_fpr.pop_front();
        chk("fpr_waddr", fpr_waddr, w.a);
        chk("fpr_wdata", fpr_wdata, w.d);
      end
    end
    if (x_valid && x_ready) begin
      if (exp_x.size() == 0) unexpected("x_result");
      else begin
        e = exp_x.pop_front();
        chk("x_id", x_id, e.id);
        chk("x_rd", x_rd, e.rd);
        chk("x_data", x_data, e.data);
      end
    end
    if (wb_valid) begin
      if (exp_wb.size() == 0) unexpected("wb_id");
      else begin
        id = exp_wb.pop_front();
        chk("wb_id", wb_id, id);
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_fpr_we"}, fpr_we, 1'b0);
    chk({tag, "_x_valid"}, x_valid, 1'b0);
    chk({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_stall"}, stall_cnt, 16'd0);
    chk({tag, "_fpr_wdata"}, fpr_wdata, 32'd0);
    chk({tag, "_ready"}, fpu_ready, 1'b1);
  endtask

  task automatic idle_inputs();
    fpu_valid = 0; fpu_rd_is_fp = 0; fpu_rd = 0; fpu_id = 0; fpu_data = 0;
    mem_valid = 0; mem_we = 0; mem_rd = 0; mem_data = 0; x_ready = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    mstall = 0;
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    // Fall-through FP result with empty queue writes back in the same cycle.
    s = '0; s.fv = 1; s.ffp = 1; s.frd = 5'd3; s.fid = 4'd1; s.fdata = 32'h3F800000;
    step(s);

    // Load write takes the port; the FP result waits one cycle.
    s = '0; s.fv = 1; s.ffp = 1; s.frd = 5'd7; s.fid = 4'd2; s.fdata = 32'h40000000;
    s.mv = 1; s.mwe = 1; s.mrd = 5'd5; s.mdata = 32'hCAFEF00D;
    step(s);
    s = '0; step(s);
    step(s);

    // Integer result held for three cycles of back-pressure.
    s = '0; s.fv = 1; s.fid = 4'd9; s.frd = 5'd11; s.fdata = 32'h12345678;
    step(s);
    s = '0; step(s); step(s);
    s.xr = 1; step(s);

    // Fill the queue behind a blocked head, then drain in order.
    s = '0; s.fv = 1; s.fid = 4'd1; s.frd = 5'd1; s.fdata = 32'h11; step(s);
    s.ffp = 1; s.fid = 4'd2; s.frd = 5'd2; s.fdata = 32'h22; step(s);
    s.ffp = 0; s.fid = 4'd3; s.frd = 5'd3; s.fdata = 32'h33; step(s);
    s = '0; s.xr = 1; step(s); step(s); step(s);

    // Long run of load writes with an FP head waiting: counter saturates.
    s = '0; s.fv = 1; s.ffp = 1; s.frd = 5'd9; s.fid = 4'd5; s.fdata = 32'hABCD;
    s.mv = 1; s.mwe = 1; s.mrd = 5'd4; s.mdata = 32'h1;
    step(s);
    s.fv = 0;
    for (int unsigned i = 0; i < 65540; i++) begin
      s.mdata = i;
      step(s);
    end
    s = '0; step(s); step(s);

    for (int i = 0; i < 2000; i++) begin
      s.fv = $urandom_range(0, 1);
      s.ffp = $urandom_range(0, 1);
      s.frd = 5'($urandom);
      s.fid = 4'($urandom);
      s.fdata = $urandom;
      s.mv = ($urandom_range(0, 9) < 3);
      s.mwe = $urandom_range(0, 1);
      s.mrd = 5'($urandom);
      s.mdata = $urandom;
      s.xr = ($urandom_range(0, 9) < 6);
      step(s);
    end

    // Reset with two queued entries: outputs drop at once, nothing stale afterwards.
    s = '0; s.fv = 1; s.fid = 4'd6; s.frd = 5'd6; step(s);
    s.ffp = 1; s.fid = 4'd7; s.frd = 5'd7; step(s);
    s = '0; step(s);
    @(posedge clk);
    #1 idle_inputs();
    x_ready = 1'b1;
    #1 rst_ni = 1'b0;
    #1 check_quiet("async_reset");
    mq.delete();
    mstall = 0;
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    s = '0; s.xr = 1;
    repeat (4) step(s);

    @(posedge clk);
    @(posedge clk);
    chk("pending_fpr", exp_fpr.size(), 0);
    chk("pending_x", exp_x.size(), 0);
    chk("pending_wb", exp_wb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
